// File: rtl/xadc_sample_filter.sv
// rtl/xadc_sample_filter.sv - box-car average, hysteresis level and min/max of XADC DRP samples
module xadc_sample_filter #(
    parameter int          LOG2_N = 4,
    parameter logic [15:0] HYST   = 16'h0200
) (
    input  logic        CLK100MHZ,
    input  logic        RESET_N,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    input  logic        clear,
    output logic        avg_valid,
    output logic [15:0] avg_data,
    output logic [3:0]  level,
    output logic [15:0] min_data,
    output logic [15:0] max_data
);
    localparam int AW = 12 + LOG2_N;
    localparam int CW = (LOG2_N == 0) ? 1 : LOG2_N;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_N) - 1);

    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          first_avg;

    logic          accept;
    logic          last;
    logic [11:0]   raw;
    logic [15:0]   raw_lj;
    logic [AW-1:0] sum;
    logic [11:0]   avg12;
    logic [15:0]   avg_new;
    logic [3:0]    c;
    logic [16:0]   a17;
    logic [16:0]   l17;
    logic          go_up;
    logic          go_down;

    assign raw     = sample_data[15:4];
    assign raw_lj  = {raw, 4'h0};
    assign accept  = sample_valid && !clear;
    assign last    = (cnt == CNT_LAST);
    assign sum     = acc + AW'(raw);
    assign avg12   = 12'(sum >> LOG2_N);
    assign avg_new = {avg12, 4'h0};
    assign c       = avg12[11:8];

    // 17-bit compares so the margins cannot wrap near either end of the code range
    assign a17     = {1'b0, avg_new};
    assign l17     = {1'b0, level, 12'h000};
    assign go_up   = (c > level) && (a17 >= l17 + 17'h01000 + {1'b0, HYST});
    assign go_down = (c < level) && (a17 + {1'b0, HYST} < l17);

    always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            acc       <= '0;
            cnt       <= '0;
            first_avg <= 1'b1;
            avg_valid <= 1'b0;
            avg_data  <= 16'h0000;
            level     <= 4'h0;
            min_data  <= 16'hFFF0;
            max_data  <= 16'h0000;
        end else begin
            avg_valid <= 1'b0;
            if (clear) begin
                acc       <= '0;
                cnt       <= '0;
                first_avg <= 1'b1;
                min_data  <= 16'hFFF0;
                max_data  <= 16'h0000;
            end else if (accept) begin
                if (raw_lj < min_data) min_data <= raw_lj;
                if (raw_lj > max_data) max_data <= raw_lj;
                if (last) begin
                    acc       <= '0;
                    cnt       <= '0;
                    avg_valid <= 1'b1;
                    avg_data  <= avg_new;
                    if (first_avg) begin
                        level     <= c;
                        first_avg <= 1'b0;
                    end else if (go_up || go_down) begin
                        level <= c;
                    end
                end else begin
                    acc <= sum;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_xadc_sample_filter.sv
// tb/tb_xadc_sample_filter.sv - directed self-checking bench for xadc_sample_filter
module tb_xadc_sample_filter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        clear;
    logic        avg_valid;
    logic [15:0] avg_data;
    logic [3:0]  level;
    logic [15:0] min_data;
    logic [15:0] max_data;

    int checks = 0;
    int failures = 0;

    xadc_sample_filter #(.LOG2_N(2), .HYST(16'h0200)) dut (
        .CLK100MHZ   (clk),
        .RESET_N     (rst_n),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .clear       (clear),
        .avg_valid   (avg_valid),
        .avg_data    (avg_data),
        .level       (level),
        .min_data    (min_data),
        .max_data    (max_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One strobe; returns at the next falling edge, where the result is visible
    task automatic send(input logic [15:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        @(negedge clk);
        sample_valid = 1'b0;
        sample_data  = 16'h0000;
    endtask

    task automatic send4(input logic [15:0] d, input string tag);
        for (int i = 0; i < 3; i++) send(d);
        send(d);
        chk({tag, "_valid"}, {15'h0, avg_valid}, 16'h0001);
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample_data  = 16'h0000;
        clear        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_avg_valid", {15'h0, avg_valid}, 16'h0000);
        chk("rst_avg_data", avg_data, 16'h0000);
        chk("rst_level", {12'h0, level}, 16'h0000);
        chk("rst_min", min_data, 16'hFFF0);
        chk("rst_max", max_data, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Two samples then an asynchronous reset mid-frame
        send(16'h5000);
        send(16'h6000);
        chk("pre_rst_max", max_data, 16'h6000);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_min", min_data, 16'hFFF0);
        chk("midrst_max", max_data, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic average; also proves the counter restarted after reset
        send(16'h1000);
        chk("basic_nv1", {15'h0, avg_valid}, 16'h0000);
        send(16'h2000);
        chk("basic_nv2", {15'h0, avg_valid}, 16'h0000);
        send(16'h3000);
        chk("basic_nv3", {15'h0, avg_valid}, 16'h0000);
        send(16'h400F);
        chk("basic_valid", {15'h0, avg_valid}, 16'h0001);
        chk("basic_avg", avg_data, 16'h2800);
        chk("basic_level", {12'h0, level}, 16'h0002);
        chk("basic_min", min_data, 16'h1000);
        chk("basic_max", max_data, 16'h4000);
        @(negedge clk);
        chk("basic_pulse_end", {15'h0, avg_valid}, 16'h0000);

        // Upward hysteresis
        send4(16'h3100, "up1");
        chk("up1_avg", avg_data, 16'h3100);
        chk("up1_level", {12'h0, level}, 16'h0002);
        send4(16'h3200, "up2");
        chk("up2_avg", avg_data, 16'h3200);
        chk("up2_level", {12'h0, level}, 16'h0003);

        // Downward hysteresis
        send4(16'h2F00, "dn1");
        chk("dn1_avg", avg_data, 16'h2F00);
        chk("dn1_level", {12'h0, level}, 16'h0003);
        send4(16'h2D00, "dn2");
        chk("dn2_avg", avg_data, 16'h2D00);
        chk("dn2_level", {12'h0, level}, 16'h0002);
        chk("dn2_min", min_data, 16'h1000);
        chk("dn2_max", max_data, 16'h4000);

        // Clear mid-frame
        send(16'h1000);
        send(16'h1000);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_min", min_data, 16'hFFF0);
        chk("clr_max", max_data, 16'h0000);
        chk("clr_avg_hold", avg_data, 16'h2D00);
        chk("clr_level_hold", {12'h0, level}, 16'h0002);
        send(16'h8000);
        send(16'h8000);
        send(16'h8000);
        chk("clr_nv3", {15'h0, avg_valid}, 16'h0000);
        send(16'h8000);
        chk("clr_valid", {15'h0, avg_valid}, 16'h0001);
        chk("clr_avg", avg_data, 16'h8000);
        chk("clr_level", {12'h0, level}, 16'h0008);
        chk("clr_min2", min_data, 16'h8000);
        chk("clr_max2", max_data, 16'h8000);

        // Clear coincident with a strobe discards the sample
        clear        = 1'b1;
        sample_valid = 1'b1;
        sample_data  = 16'h0100;
        @(negedge clk);
        clear        = 1'b0;
        sample_valid = 1'b0;
        chk("coin_min", min_data, 16'hFFF0);
        chk("coin_max", max_data, 16'h0000);

        // Eight back-to-back strobes: pulses on the 4th and 8th
        sample_valid = 1'b1;
        sample_data  = 16'hA000;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 8) sample_valid = 1'b0;
            chk($sformatf("b2b_valid%0d", i), {15'h0, avg_valid},
                (i == 4 || i == 8) ? 16'h0001 : 16'h0000);
            if (i == 4 || i == 8) chk($sformatf("b2b_avg%0d", i), avg_data, 16'hA000);
        end
        chk("b2b_level", {12'h0, level}, 16'h000A);
        chk("b2b_min", min_data, 16'hA000);
        @(negedge clk);
        chk("b2b_pulse_end", {15'h0, avg_valid}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xadc_sample_filter.md
# xadc_sample_filter

Downstream conditioning stage for the XADC DRP read path. Accepts each converted sample qualified by the DRP ready strobe, box-car averages 2^LOG2_N samples, and publishes a left-justified average, a hysteresis-stabilised 4-bit level for the LED bar and `data_digital`, and running min/max. Its outputs replace raw DRP data as the source for the LED bar and the binary-to-decimal/seven-segment path.

## Interface
- `LOG2_N`, default 4: log2 of the samples per average; legal range 0..8.
- `HYST`, default 16'h0200: hysteresis margin in left-justified 16-bit codes.
- `CLK100MHZ` in 1: the only clock; all logic is on its rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `sample_valid` in 1: one-cycle strobe, driven from DRP `drdy_out`.
- `sample_data` in 16: DRP `do_out`. The 12-bit result is bits [15:4]; bits [3:0] are ignored.
- `clear` in 1: synchronous restart of accumulation and statistics.
- `avg_valid` out 1: one-cycle pulse that fires when a new average is published.
- `avg_data` out 16: the average, 12 bits left-justified, with [3:0] = 0.
- `level` out 4: quantised average with hysteresis.
- `min_data` out 16: smallest accepted sample since the last reset or clear, left-justified.
- `max_data` out 16: largest accepted sample since the last reset or clear, left-justified.

## Operation
- `raw` = `sample_data[15:4]`.
- The accumulator is 12+LOG2_N bits wide. The sample counter is LOG2_N bits wide and wraps.
- A sample is accepted when `sample_valid`=1 and `clear`=0.
- **Non-final accepted sample** (counter ≠ 2^LOG2_N−1): `acc += raw`, `counter += 1`.
- **Final accepted sample** (counter = 2^LOG2_N−1):
  - `sum` = `acc` + `raw`.
  - `avg_data` ← {`sum` >> LOG2_N, 4'h0}; the division is truncating.
  - `avg_valid` ← 1.
  - `acc` ← 0 and `counter` ← 0.
  - `level` is updated in the same edge from the new average.
- **Level rule**: let `a` be the new `avg_data`, `c` = `a[15:12]`, and `L` = {`level`, 12'h000}. All comparisons use 17-bit arithmetic, so there is no wrap.
  - If the first-average flag is set: `level` ← `c` unconditionally, and the flag clears.
  - Else if `c` > `level` and `a` ≥ `L` + 16'h1000 + `HYST`: `level` ← `c`.
  - Else if `c` < `level` and `a` + `HYST` < `L`: `level` ← `c`.
  - Otherwise `level` holds.
- **Min/max**: updated on every accepted sample, comparing {`raw`, 4'h0}. A tie leaves the value unchanged.
- **`clear`** (synchronous):
  - `acc` ← 0 and `counter` ← 0.
  - `min_data` ← 16'hFFF0 and `max_data` ← 16'h0000.
  - The first-average flag is set.
  - `avg_data` and `level` hold.
  - If `clear` and `sample_valid` coincide, `clear` wins and the sample is discarded.
- With LOG2_N=0, every accepted sample is final.

## Timing
- **Reset values** (forced immediately while `RESET_N`=0, including mid-frame): `avg_valid`=0, `avg_data`=16'h0000, `level`=4'h0, `min_data`=16'hFFF0, `max_data`=16'h0000, `acc`=0, `counter`=0, first-average flag set.
- **Average latency**: `avg_valid`, `avg_data` and `level` change on the edge that samples the final `sample_valid`. They are visible the next cycle.
- `avg_valid` is high for exactly one cycle.
- **Min/max latency**: `min_data` and `max_data` reflect a sample one cycle after its strobe.
- `sample_valid` may be asserted every cycle. There is no backpressure and no sample is dropped except on `clear`.
- The combinational path (adder, shift and 17-bit compare) must close at 100 MHz. Registering it is not permitted, because the latency above is fixed.

## Test plan
All scenarios use LOG2_N=2 and HYST=16'h0200.
- **Reset**: hold `RESET_N`=0 -> `avg_data`=0000, `level`=0, `min_data`=FFF0, `max_data`=0000, `avg_valid`=0. Then assert `RESET_N`=0 after 2 accepted samples -> the counter restarts, and 4 further samples are needed for a pulse.
- **Basic average**: samples 1000, 2000, 3000, 400F -> one-cycle `avg_valid` after the 4th, `avg_data`=2800, `level`=2 (first average), `min_data`=1000, `max_data`=4000.
- **Upward hysteresis**: from `level`=2, four samples of 3100 -> `avg_data`=3100, `level` stays 2. Four samples of 3200 -> `level`=3.
- **Downward hysteresis**: from `level`=3, average 2F00 -> `level` stays 3. Average 2D00 -> `level`=2.
- **Clear mid-frame**: 2 samples of 1000, `clear`, then 4 samples of 8000 -> `avg_data`=8000, `level`=8 (the flag forces the update), `min_data`=`max_data`=8000.
- **Clear/sample coincidence and back-to-back strobes**: `clear` coincident with `sample_valid` -> that sample is ignored. Then 8 consecutive strobes of A000 -> two `avg_valid` pulses, 4 cycles apart, both with `avg_data`=A000.
